// File: rtl/mrx_deserializer.sv
// Receive-side packetizer: assembles 8/16/32/64-bit beats LSB-first into PW-bit
// packets with a byte-valid mask, buffered in a 2-entry output queue.
module mrx_deserializer #(
    parameter int IOW = 64,
    parameter int PW  = 64
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [1:0]        iowidth,
    input  logic              clr,
    input  logic              rx_access,
    input  logic [IOW-1:0]    rx_packet,
    output logic              rx_wait,
    output logic              out_access,
    output logic [PW-1:0]     out_packet,
    output logic [PW/8-1:0]   out_valid,
    input  logic              out_wait,
    output logic              overflow,
    output logic [15:0]       pkt_count
);

    localparam int NB     = PW / 8;
    localparam int IB     = IOW / 8;
    localparam int PTRW   = $clog2(NB) + 1;
    localparam int EW     = PW + NB;
    localparam logic [1:0] MAXW = 2'($clog2(IB));

    logic [PW-1:0]   asm_q, asm_d;
    logic [NB-1:0]   mask_q, mask_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [1:0]      wlog_q, wlog_d;
    logic [EW-1:0]   q0_q, q0_d, q1_q, q1_d;
    logic [1:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     pkt_count_q, pkt_count_d;

    logic [1:0]      iow_clamp;
    logic [1:0]      cur_wlog;
    int              bb;
    logic            push, push_acc, pop;
    logic [PW-1:0]   push_data;
    logic [NB-1:0]   push_mask;

    always_comb begin
        asm_d       = asm_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        wlog_d      = wlog_q;
        q0_d        = q0_q;
        q1_d        = q1_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        pkt_count_d = pkt_count_q;
        push        = 1'b0;
        push_data   = '0;
        push_mask   = '0;

        // The beat width is only resampled when the assembly is empty.
        iow_clamp = (iowidth > MAXW) ? MAXW : iowidth;
        cur_wlog  = (mask_q == '0) ? iow_clamp : wlog_q;
        bb        = 1 << cur_wlog;

        if (rx_access) begin
            wlog_d = cur_wlog;
            for (int j = 0; j < IB; j++) begin
                if (j < bb && (int'(ptr_q) + j) < NB) begin
                    asm_d[(int'(ptr_q) + j) * 8 +: 8] = rx_packet[j * 8 +: 8];
                    mask_d[int'(ptr_q) + j]           = 1'b1;
                end
            end
            if (int'(ptr_q) + bb == NB) begin
                push      = 1'b1;
                push_data = asm_d;
                push_mask = '1;
                mask_d    = '0;
                ptr_d     = '0;
            end else begin
                ptr_d = PTRW'(int'(ptr_q) + bb);
            end
        end else if (mask_q != '0) begin
            push      = 1'b1;
            push_data = asm_q;
            push_mask = mask_q;
            mask_d    = '0;
            ptr_d     = '0;
        end

        pop      = (count_q != 2'd0) && !out_wait;
        push_acc = push && ((count_q != 2'd2) || pop);

        // Pop shifts the tail forward; a push lands behind whatever remains.
        if (pop) begin
            q0_d = q1_q;
        end
        if (push_acc) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                q0_d = {push_mask, push_data};
            end else begin
                q1_d = {push_mask, push_data};
            end
        end

        if (push_acc && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push_acc && pop) begin
            count_d = count_q - 2'd1;
        end

        if (clr) begin
            overflow_d  = 1'b0;
            pkt_count_d = '0;
        end else begin
            if (push && !push_acc) begin
                overflow_d = 1'b1;
            end
            if (push_acc) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            asm_q       <= '0;
            mask_q      <= '0;
            ptr_q       <= '0;
            wlog_q      <= '0;
            q0_q        <= '0;
            q1_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            asm_q       <= asm_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            wlog_q      <= wlog_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign out_access = (count_q != 2'd0);
    assign out_packet = out_access ? q0_q[PW-1:0] : '0;
    assign out_valid  = out_access ? q0_q[EW-1:PW] : '0;
    assign rx_wait    = (count_q == 2'd2);
    assign overflow   = overflow_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: doc/mrx_deserializer.md
Name: mrx_deserializer

Overview:
- Parametrised receive-side packetizer for the MIO link.
- Takes SDR beats of 8/16/32/64 bits from the pad-capture stage and assembles them LSB-first into PW-bit packets, with a per-byte valid mask.
- Buffers assembled packets in a 2-entry output queue with wait backpressure toward the core FIFO, and raises wait upstream when full.
- Flushes a partial packet at end of frame, counts packets, and flags overflow.

Parameters:
- IOW, 64, max input beat width in bits; one of 8, 16, 32, 64.
- PW, 64, packet width in bits; multiple of 8, PW >= IOW, PW/IOW a power of 2.

Ports:
- clk  input  1  clock
- nreset  input  1  synchronous active-low reset
- iowidth  input  2  beat width: 00=8, 01=16, 10=32, 11=64 bits; clamped to IOW
- clr  input  1  clears overflow and pkt_count
- rx_access  input  1  beat valid / frame envelope
- rx_packet  input  IOW  beat data; lane 0 in bits [7:0]
- rx_wait  output  1  queue full; upstream must stall
- out_access  output  1  queue head valid
- out_packet  output  PW  queue head data
- out_valid  output  PW/8  byte-valid mask of queue head
- out_wait  input  1  core not ready; head is held
- overflow  output  1  sticky; a packet was dropped
- pkt_count  output  16  packets pushed, wraps

Behaviour:
- Reset is synchronous: nreset=0 at a clk edge clears all state. After reset: out_access=0, out_valid=0, out_packet=0, rx_wait=0, overflow=0, pkt_count=0, assembly empty, queue empty.
- A reset mid-frame discards the partial packet and all queued packets.
- NB=PW/8. BB (bytes per beat) = 2^iowidth, clamped to IOW/8.
- iowidth is sampled on the first beat of a frame, when the assembly is empty and rx_access=1. The sampled value holds until the assembly next empties; changes mid-frame are ignored.
- Assembly:
  - Byte pointer ptr starts at 0.
  - Each clk with rx_access=1 writes beat bytes [BB-1:0] into assembly bytes ptr..ptr+BB-1 and sets the corresponding mask bits.
  - ptr advances by BB.
- Full push:
  - Fires when ptr+BB==NB on a beat.
  - The assembled packet, including the current beat, is pushed with mask all-ones.
  - ptr and mask reset to 0 on the same edge, so back-to-back beats continue with no bubble.
- Partial push (flush):
  - Fires in any cycle with rx_access=0 and a non-empty mask.
  - Pushes the current data and mask; unused bytes keep stale contents, and the mask marks them invalid.
  - The assembly then empties.
  - A one-cycle rx_access gap ends a frame.
- Queue:
  - 2 entries, in order.
  - out_access=1 whenever the queue is non-empty; out_packet and out_valid show the head.
  - Pop occurs when out_access=1 and out_wait=0.
  - While out_wait=1, the head is stable.
- Push/pop rules:
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - A push with count==2 and no pop drops the packet, sets overflow=1, and leaves pkt_count unchanged.
  - Assembly continues regardless of a drop.
- rx_wait = (count==2), registered with count. Upstream stalls by holding rx_access=0, which may trigger a flush; partial packets are legal.
- Latency: the packet completing on the edge at beat t is visible on out_* in cycle t+1 if the queue was empty.
- pkt_count increments by 1 per accepted push and wraps 0xFFFF->0.
- clr takes effect next edge. If clr and a drop occur in the same cycle, clr wins and overflow=0.
- rx_packet bits above BB*8 are ignored.

Test Plan:
- IOW=64, PW=64, iowidth=00, 8 beats 0x11..0x88, rx_access then low -> 1 cycle after the 8th beat: out_packet=0x8877665544332211, out_valid=0xFF, pkt_count=1.
- iowidth=01, 3 beats 0xAAAA,0xBBBB,0xCCCC then gap -> cycle after the gap: out_valid=0x3F, out_packet[47:0]=0xCCCCBBBBAAAA.
- iowidth=11, 4 continuous beats with out_wait=0 -> 4 pushes with no bubble, out_access high 4 consecutive cycles, pkt_count=4.
- out_wait=1 held, 3 full packets pushed -> rx_wait=1 after 2 pushes; 3rd packet dropped; overflow=1; head stays packet 1; release out_wait -> packets 1 and 2 pop in order; clr -> overflow=0, pkt_count=0.
- iowidth changed 00->11 after 2 bytes of a frame -> remainder still assembled as 8-bit beats; new width applies on the next frame.
- nreset low while 5 bytes are assembled and 1 packet is queued -> next cycle: out_access=0, pkt_count=0, and a subsequent 8-byte frame assembles from byte 0.
